// File: rtl/conv_pkg.sv
// Shared constants, state type and helpers for the 3x3 convolution datapath.
// Imported by the convolver output-side blocks.
package conv_pkg;

    localparam int PIX_W        = 8;
    localparam int IMG_W_DEF    = 64;
    localparam int IMG_H_DEF    = 64;
    localparam int CONV_LATENCY = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Bits needed to hold values 0..value-1, never less than one.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) w++;
        return w;
    endfunction

endpackage

// File: rtl/valid_delay_line.sv
// Fixed-depth shift register that carries stream strobes alongside a
// pipelined datapath so they line up with its output.
module valid_delay_line #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] taps [DEPTH];

    // Shift every cycle; reset flushes whatever is in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) taps[i] <= '0;
        end else begin
            taps[0] <= din;
            for (int i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
        end
    end

    assign dout = taps[DEPTH-1];

endmodule

// File: rtl/conv_result_writer.sv
// Write-back sink for the convolver: realigns column strobes with the
// result stream, drops warm-up columns and fills the result RAM row-major.
module conv_result_writer
    import conv_pkg::*;
#(
    parameter int IMG_W   = IMG_W_DEF,
    parameter int IMG_H   = IMG_H_DEF,
    parameter int LATENCY = CONV_LATENCY,
    parameter int ADDR_W  = clog2((IMG_W-2)*(IMG_H-2))
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic              row_start,
    input  logic [PIX_W-1:0]  pix_in,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [PIX_W-1:0]  wr_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int N_PIX = (IMG_W-2)*(IMG_H-2);
    localparam int COL_W = clog2(IMG_W);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_PIX-1);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IMG_W-1);
    localparam logic [COL_W-1:0]  COL_WR    = COL_W'(2);

    state_t state;
    state_t state_next;

    logic [1:0]        taps;
    logic              dv;
    logic              drs;
    logic [COL_W-1:0]  col;
    logic [COL_W-1:0]  col_eff;
    logic [ADDR_W-1:0] addr_cnt;
    logic              first_beat;
    logic              accept;
    logic              beat;
    logic              write;
    logic              early_rs;
    logic              last_write;
    logic              busy_d;
    logic              done_d;

    valid_delay_line #(
        .DEPTH (LATENCY),
        .WIDTH (2)
    ) u_delay (
        .clock (clock),
        .reset (reset),
        .din   ({in_valid, row_start}),
        .dout  (taps)
    );

    assign {dv, drs} = taps;

    // Beat decode: a delayed column only counts while a frame is running.
    assign accept     = start && (state == IDLE) && !busy;
    assign beat       = dv && (state == RUN);
    assign col_eff    = drs ? '0 : col;
    assign write      = beat && (col_eff >= COL_WR);
    assign early_rs   = beat && drs && (col != '0) && !first_beat;
    assign last_write = write && (addr_cnt == LAST_ADDR);

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next state: arm on start, stop on the final address, one DONE cycle.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (accept) state_next = RUN;
            RUN:     if (last_write) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Status outputs: busy also covers the cycle carrying the done pulse.
    always_comb begin
        busy_d = (state_next != IDLE) || (state == DONE);
        done_d = (state == DONE);
    end

    // Column tracking, running write address and registered RAM port.
    always_ff @(posedge clock) begin
        if (reset) begin
            col        <= '0;
            addr_cnt   <= '0;
            first_beat <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            wr_en <= write;
            busy  <= busy_d;
            done  <= done_d;
            if (accept) begin
                col        <= '0;
                addr_cnt   <= '0;
                first_beat <= 1'b1;
                err        <= 1'b0;
            end
            if (beat) begin
                first_beat <= 1'b0;
                col        <= (col_eff == COL_LAST) ? '0 : col_eff + 1'b1;
                if (early_rs) err <= 1'b1;
            end
            if (write) begin
                wr_addr  <= addr_cnt;
                wr_data  <= pix_in;
                addr_cnt <= addr_cnt + 1'b1;
            end
        end
    end

endmodule
